// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter shared by the I-cache and D-cache: allocates transaction IDs,
// grants one requester per cycle and broadcasts tagged responses until the owner acks.
module mem_port_arbiter #(
  parameter int PA_WIDTH  = 32,
  parameter int REG_WIDTH = 128,
  parameter int ID_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ica_req,
  input  logic [PA_WIDTH-1:0]  i_ica_addr,
  input  logic                 i_ica_ack,
  output logic                 o_ica_in_use,
  input  logic                 i_dca_req,
  input  logic                 i_dca_we,
  input  logic [PA_WIDTH-1:0]  i_dca_addr,
  input  logic [REG_WIDTH-1:0] i_dca_wdata,
  input  logic                 i_dca_ack,
  output logic                 o_dca_in_use,
  output logic [ID_WIDTH-1:0]  o_id_request,
  output logic                 o_resp_enable,
  output logic [ID_WIDTH-1:0]  o_resp_id,
  output logic [REG_WIDTH-1:0] o_resp_data,
  output logic                 o_mem_req_valid,
  output logic                 o_mem_req_we,
  output logic [PA_WIDTH-1:0]  o_mem_req_addr,
  output logic [REG_WIDTH-1:0] o_mem_req_wdata,
  output logic [ID_WIDTH-1:0]  o_mem_req_id,
  input  logic                 i_mem_req_ready,
  input  logic                 i_mem_resp_valid,
  input  logic [ID_WIDTH-1:0]  i_mem_resp_id,
  input  logic [REG_WIDTH-1:0] i_mem_resp_data,
  output logic                 o_mem_resp_ready,
  output logic                 o_err
);
  localparam int N_IDS = 2 ** ID_WIDTH;

  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  logic [N_IDS-1:0]     r_in_flight;
  src_e                 r_owner [N_IDS];
  src_e                 r_last_grant;
  logic                 r_resp_full;
  logic [ID_WIDTH-1:0]  r_resp_id;
  logic [REG_WIDTH-1:0] r_resp_data;
  logic                 r_err;

  logic                 w_full;
  logic                 w_blocked;
  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_grant;
  src_e                 w_winner;
  logic [ID_WIDTH-1:0]  w_free_id;
  src_e                 w_resp_owner;
  logic                 w_ack;
  logic                 w_resp_accept;
  logic                 w_resp_known;

  // Scanning from the top down leaves the lowest free ID in w_free_id.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_free_id = '0;
    for (int i = N_IDS - 1; i >= 0; i--) begin
      if (!r_in_flight[i]) w_free_id = ID_WIDTH'(i);
    end
  end

  assign w_full    = &r_in_flight;
  assign w_blocked = w_full || !i_mem_req_ready;

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!w_blocked) begin
      if (i_ica_req && i_dca_req) begin
        w_grant_i = (r_last_grant == SRC_D);
        w_grant_d = (r_last_grant == SRC_I);
      end else begin
        w_grant_i = i_ica_req;
        w_grant_d = i_dca_req;
      end
    end
  end

  assign w_grant  = w_grant_i || w_grant_d;
  assign w_winner = w_grant_d ? SRC_D : SRC_I;

  assign o_ica_in_use    = w_blocked || w_grant_d;
  assign o_dca_in_use    = w_blocked || w_grant_i;
  assign o_id_request    = w_free_id;
  assign o_mem_req_valid = w_grant;
  assign o_mem_req_we    = w_grant_d && i_dca_we;
  assign o_mem_req_addr  = w_grant_d ? i_dca_addr : i_ica_addr;
  assign o_mem_req_wdata = w_grant_d ? i_dca_wdata : '0;
  assign o_mem_req_id    = w_free_id;

  // Only the cache that issued the held ID may retire it.
  assign w_resp_owner = r_owner[r_resp_id];
  assign w_ack        = r_resp_full &&
                        ((i_ica_ack && (w_resp_owner == SRC_I)) ||
                         (i_dca_ack && (w_resp_owner == SRC_D)));

  assign o_mem_resp_ready = !r_resp_full || w_ack;
  assign w_resp_accept    = i_mem_resp_valid && o_mem_resp_ready;
  assign w_resp_known     = r_in_flight[i_mem_resp_id];

  assign o_resp_enable = r_resp_full;
  assign o_resp_id     = r_resp_id;
  assign o_resp_data   = r_resp_data;
  assign o_err         = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_flight  <= '0;
      r_last_grant <= SRC_D;
      r_resp_full  <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_err        <= 1'b0;
      // NOTE: the owner table is only a few flops, so it is reset with the rest of the state.
      for (int i = 0; i < N_IDS; i++) r_owner[i] <= SRC_I;
    end else begin
      // NOTE: non-blocking assignments keep every read in this block on pre-edge values.
      if (w_ack) begin
        r_in_flight[r_resp_id] <= 1'b0;
        r_resp_full            <= 1'b0;
      end
      if (w_grant) begin
        r_in_flight[w_free_id] <= 1'b1;
        r_owner[w_free_id]     <= w_winner;
        r_last_grant           <= w_winner;
      end
      if (w_resp_accept) begin
        if (w_resp_known) begin
          r_resp_full <= 1'b1;
          r_resp_id   <= i_mem_resp_id;
          r_resp_data <= i_mem_resp_data;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  a_single_ack : assert property (@(posedge clk) disable iff (rst) !(i_ica_ack && i_dca_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected requests/responses go into queues
// and a monitor process compares them whenever the DUT presents a request or broadcast.
module tb_mem_port_arbiter;
  localparam int PA_WIDTH  = 32;
  localparam int REG_WIDTH = 128;
  localparam int ID_WIDTH  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 i_ica_req;
  logic [PA_WIDTH-1:0]  i_ica_addr;
  logic                 i_ica_ack;
  logic                 o_ica_in_use;
  logic                 i_dca_req;
  logic                 i_dca_we;
  logic [PA_WIDTH-1:0]  i_dca_addr;
  logic [REG_WIDTH-1:0] i_dca_wdata;
  logic                 i_dca_ack;
  logic                 o_dca_in_use;
  logic [ID_WIDTH-1:0]  o_id_request;
  logic                 o_resp_enable;
  logic [ID_WIDTH-1:0]  o_resp_id;
  logic [REG_WIDTH-1:0] o_resp_data;
  logic                 o_mem_req_valid;
  logic                 o_mem_req_we;
  logic [PA_WIDTH-1:0]  o_mem_req_addr;
  logic [REG_WIDTH-1:0] o_mem_req_wdata;
  logic [ID_WIDTH-1:0]  o_mem_req_id;
  logic                 i_mem_req_ready;
  logic                 i_mem_resp_valid;
  logic [ID_WIDTH-1:0]  i_mem_resp_id;
  logic [REG_WIDTH-1:0] i_mem_resp_data;
  logic                 o_mem_resp_ready;
  logic                 o_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .PA_WIDTH (PA_WIDTH),
    .REG_WIDTH(REG_WIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_ica_req       (i_ica_req),
    .i_ica_addr      (i_ica_addr),
    .i_ica_ack       (i_ica_ack),
    .o_ica_in_use    (o_ica_in_use),
    .i_dca_req       (i_dca_req),
    .i_dca_we        (i_dca_we),
    .i_dca_addr      (i_dca_addr),
    .i_dca_wdata     (i_dca_wdata),
    .i_dca_ack       (i_dca_ack),
    .o_dca_in_use    (o_dca_in_use),
    .o_id_request    (o_id_request),
    .o_resp_enable   (o_resp_enable),
    .o_resp_id       (o_resp_id),
    .o_resp_data     (o_resp_data),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_req_we    (o_mem_req_we),
    .o_mem_req_addr  (o_mem_req_addr),
    .o_mem_req_wdata (o_mem_req_wdata),
    .o_mem_req_id    (o_mem_req_id),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_id   (i_mem_resp_id),
    .i_mem_resp_data (i_mem_resp_data),
    .o_mem_resp_ready(o_mem_resp_ready),
    .o_err           (o_err)
  );

  typedef struct {
    logic                 we;
    logic [PA_WIDTH-1:0]  addr;
    logic                 chk_wdata;
    logic [REG_WIDTH-1:0] wdata;
    logic [ID_WIDTH-1:0]  id;
  } req_t;

  typedef struct {
    logic [ID_WIDTH-1:0]  id;
    logic [REG_WIDTH-1:0] data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [REG_WIDTH-1:0] act,
                       input logic [REG_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    i_ica_req        = 1'b0;
    i_ica_addr       = '0;
    i_ica_ack        = 1'b0;
    i_dca_req        = 1'b0;
    i_dca_we         = 1'b0;
    i_dca_addr       = '0;
    i_dca_wdata      = '0;
    i_dca_ack        = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_id    = '0;
    i_mem_resp_data  = '0;
  endtask

  task automatic exp_req(input logic we, input logic [PA_WIDTH-1:0] addr, input logic chk,
                         input logic [REG_WIDTH-1:0] wdata, input logic [ID_WIDTH-1:0] id);
    req_t e;
    e.we = we; e.addr = addr; e.chk_wdata = chk; e.wdata = wdata; e.id = id;
    req_q.push_back(e);
  endtask

  task automatic send_resp(input logic [ID_WIDTH-1:0] id, input logic [REG_WIDTH-1:0] data,
                           input logic expect_bcast);
    resp_t e;
    i_mem_resp_valid = 1'b1;
    i_mem_resp_id    = id;
    i_mem_resp_data  = data;
    if (expect_bcast) begin
      e.id = id; e.data = data;
      resp_q.push_back(e);
    end
  endtask

  // Holds reset for one sampled cycle, checks every reset-defined output, then releases.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle();
    req_q.delete();
    resp_q.delete();
    sample();
    check({tag, "_resp_enable"}, o_resp_enable, 0);
    check({tag, "_mem_req_valid"}, o_mem_req_valid, 0);
    check({tag, "_id_request"}, o_id_request, 0);
    check({tag, "_mem_resp_ready"}, o_mem_resp_ready, 1);
    check({tag, "_err"}, o_err, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin : monitor
    logic  prev_en;
    logic  prev_taken;
    req_t  er;
    resp_t es;
    prev_en    = 1'b0;
    prev_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en    = 1'b0;
        prev_taken = 1'b0;
      end else begin
        if (o_mem_req_valid) begin
          if (req_q.size() == 0) begin
            check("req_unexpected", o_mem_req_valid, 0);
          end else begin
            er = req_q.pop_front();
            check("req_addr", o_mem_req_addr, er.addr);
            check("req_we", o_mem_req_we, er.we);
            check("req_id", o_mem_req_id, er.id);
            if (er.chk_wdata) check("req_wdata", o_mem_req_wdata, er.wdata);
          end
        end
        if (o_resp_enable && (!prev_en || prev_taken)) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", o_resp_enable, 0);
          end else begin
            es = resp_q.pop_front();
            check("resp_id", o_resp_id, es.id);
            check("resp_data", o_resp_data, es.data);
          end
        end
        prev_en    = o_resp_enable;
        prev_taken = o_resp_enable && o_mem_resp_ready;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    idle();
    i_mem_req_ready = 1'b1;
    #1;
    do_reset("rst0");

    // Single I request: granted with id 0 in the same cycle, next free id is 1.
    i_ica_req = 1'b1; i_ica_addr = 32'h100;
    exp_req(1'b0, 32'h100, 1'b0, '0, 2'd0);
    sample();
    check("t1_ica_in_use", o_ica_in_use, 0);
    check("t1_id_request", o_id_request, 0);
    next_cycle(); idle();
    sample();
    check("t1_next_id", o_id_request, 1);
    next_cycle();

    // Fresh reset so last_grant = D; simultaneous requests go to I first.
    do_reset("rst1");
    i_ica_req = 1'b1; i_ica_addr = 32'h110;
    i_dca_req = 1'b1; i_dca_we = 1'b1; i_dca_addr = 32'h200; i_dca_wdata = 128'h55;
    exp_req(1'b0, 32'h110, 1'b0, '0, 2'd0);
    sample();
    check("t2_dca_in_use", o_dca_in_use, 1);
    check("t2_ica_in_use", o_ica_in_use, 0);
    next_cycle();
    i_ica_req = 1'b0;
    exp_req(1'b1, 32'h200, 1'b1, 128'h55, 2'd1);
    sample();
    check("t2_dca_granted", o_dca_in_use, 0);
    next_cycle(); idle();

    // Fill the remaining two IDs, then a fifth request is blocked.
    i_ica_req = 1'b1; i_ica_addr = 32'h300;
    exp_req(1'b0, 32'h300, 1'b0, '0, 2'd2);
    sample(); next_cycle(); idle();
    i_dca_req = 1'b1; i_dca_addr = 32'h400;
    exp_req(1'b0, 32'h400, 1'b0, '0, 2'd3);
    sample(); next_cycle(); idle();
    i_ica_req = 1'b1; i_ica_addr = 32'h500;
    sample();
    check("t3_full_ica_in_use", o_ica_in_use, 1);
    check("t3_full_dca_in_use", o_dca_in_use, 1);
    check("t3_full_no_valid", o_mem_req_valid, 0);
    next_cycle(); idle();
    send_resp(2'd2, 128'h2222, 1'b1);
    sample();
    check("t3_resp_ready", o_mem_resp_ready, 1);
    next_cycle(); idle();
    // Owner ack of id 2; the freed ID is not yet usable this cycle.
    i_ica_ack = 1'b1; i_ica_req = 1'b1; i_ica_addr = 32'h500;
    sample();
    check("t3_ack_ready", o_mem_resp_ready, 1);
    check("t3_same_cycle_in_use", o_ica_in_use, 1);
    check("t3_same_cycle_no_valid", o_mem_req_valid, 0);
    next_cycle(); idle();
    sample();
    check("t3_freed_id", o_id_request, 2);
    check("t3_resp_cleared", o_resp_enable, 0);
    next_cycle();

    // Response id 1 (owned by D) held three cycles; a non-owner ack is ignored.
    send_resp(2'd1, 128'hABCD, 1'b1);
    sample(); next_cycle(); idle();
    for (int k = 0; k < 3; k++) begin
      i_ica_ack = (k == 1);
      sample();
      check("t4_hold_en", o_resp_enable, 1);
      check("t4_hold_id", o_resp_id, 1);
      check("t4_hold_data", o_resp_data, 128'hABCD);
      check("t4_hold_ready", o_mem_resp_ready, 0);
      next_cycle();
    end
    i_ica_ack = 1'b0; i_dca_ack = 1'b1;
    sample();
    check("t4_ack_ready", o_mem_resp_ready, 1);
    next_cycle(); idle();
    sample();
    check("t4_released", o_resp_enable, 0);
    check("t4_id_after", o_id_request, 1);
    next_cycle();

    // Back-to-back: ack of id 0 and capture of id 3 in the same cycle.
    send_resp(2'd0, 128'h0A0A, 1'b1);
    sample(); next_cycle(); idle();
    i_ica_ack = 1'b1;
    send_resp(2'd3, 128'h3333, 1'b1);
    sample();
    check("t4b_ready", o_mem_resp_ready, 1);
    next_cycle(); idle();
    i_dca_ack = 1'b1;
    sample();
    check("t4b_second_en", o_resp_enable, 1);
    next_cycle(); idle();
    sample();
    check("t4b_done_en", o_resp_enable, 0);
    check("t4b_all_free", o_id_request, 0);
    check("t4b_err", o_err, 0);
    next_cycle();

    // Unknown ID is dropped and sets the sticky error.
    send_resp(2'd3, 128'hDEAD, 1'b0);
    sample();
    check("t5_ready", o_mem_resp_ready, 1);
    next_cycle(); idle();
    sample();
    check("t5_no_bcast", o_resp_enable, 0);
    check("t5_err", o_err, 1);
    next_cycle();
    // Downstream not ready blocks the grant.
    i_mem_req_ready = 1'b0; i_dca_req = 1'b1; i_dca_addr = 32'h900;
    sample();
    check("t5_nr_dca_in_use", o_dca_in_use, 1);
    check("t5_nr_no_valid", o_mem_req_valid, 0);
    next_cycle(); idle(); i_mem_req_ready = 1'b1;
    sample();
    check("t5_err_sticky", o_err, 1);
    next_cycle();

    // Two IDs in flight plus a pending broadcast, then reset mid-operation.
    i_ica_req = 1'b1; i_ica_addr = 32'h600;
    exp_req(1'b0, 32'h600, 1'b0, '0, 2'd0);
    sample(); next_cycle(); idle();
    i_dca_req = 1'b1; i_dca_addr = 32'h700;
    exp_req(1'b0, 32'h700, 1'b0, '0, 2'd1);
    sample(); next_cycle(); idle();
    send_resp(2'd0, 128'h6666, 1'b1);
    sample(); next_cycle(); idle();
    sample();
    check("t6_pending", o_resp_enable, 1);
    next_cycle();
    do_reset("rst2");
    send_resp(2'd1, 128'h7777, 1'b0);
    sample(); next_cycle(); idle();
    sample();
    check("t6_late_dropped", o_resp_enable, 0);
    check("t6_late_err", o_err, 1);
    next_cycle();
    i_ica_req = 1'b1; i_ica_addr = 32'h800;
    exp_req(1'b0, 32'h800, 1'b0, '0, 2'd0);
    sample();
    check("t6_first_id", o_id_request, 0);
    next_cycle(); idle();
    sample();
    check("req_q_empty", req_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
